pipe_hazard_ctrl: RTL and testbench
===================================

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

Interface
REQ-001 Parameter: WAIT_CYCLES, 4, total cycles a memory access occupies the MEM stage; legal range 2..8.
REQ-002 clk  input  1  single clock; all state updates on posedge clk.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 src1  input  4  ID-stage first source register number.
REQ-005 src2  input  4  ID-stage second source register number.
REQ-006 two_src  input  1  ID instruction reads src2 as well as src1.
REQ-007 exe_dest, exe_wb_en  input  4,1  EXE-stage destination register and write-back enable.
REQ-008 mem_dest, mem_wb_en  input  4,1  MEM-stage destination register and write-back enable.
REQ-009 mem_r_en, mem_w_en  input  1,1  MEM-stage read or write request.
REQ-010 branch_taken  input  1  EXE-stage branch resolved taken.
REQ-011 freeze_all  output  1  hold PC and all pipeline registers.
REQ-012 hazard_stall  output  1  hold PC and IF2ID; ID2EXE loads a bubble.
REQ-013 flush_if2id, flush_id2exe  output  1,1  clear the corresponding pipeline register on the next edge.
REQ-014 busy  output  1  FSM is in MEM_WAIT.
REQ-015 stall_cnt  output  16  saturating count of stalled cycles.

Function
REQ-016 Define mem_acc = mem_r_en | mem_w_en.
REQ-017 Define raw = (exe_wb_en & exe_dest==src1) | (mem_wb_en & mem_dest==src1) | (two_src & ((exe_wb_en & exe_dest==src2) | (mem_wb_en & mem_dest==src2))).
REQ-018 FSM states: RUN, MEM_WAIT; 3-bit down-counter wait_cnt.
REQ-019 RUN with mem_acc=1: freeze_all=1; next state MEM_WAIT; wait_cnt<=WAIT_CYCLES-2.
REQ-020 RUN with mem_acc=0: freeze_all=0; stay in RUN.
REQ-021 MEM_WAIT with wait_cnt!=0: freeze_all=1; wait_cnt decrements.
REQ-022 MEM_WAIT with wait_cnt==0 (release cycle): freeze_all=0; next state RUN. The access therefore spans exactly WAIT_CYCLES cycles, of which WAIT_CYCLES-1 are frozen.
REQ-023 Back-to-back accesses: a new access seen in RUN on the cycle after release starts a fresh sequence; no idle cycle is inserted.
REQ-024 Only mem_acc sampled in RUN starts a sequence; mem_r_en/mem_w_en are ignored while in MEM_WAIT.
REQ-025 flush_if2id = flush_id2exe = branch_taken & ~freeze_all. A branch seen during a freeze is deferred until the release cycle; branch_taken is held stable because EXE is frozen.
REQ-026 hazard_stall = raw & ~branch_taken & ~freeze_all. Branch outranks the hazard because the ID instruction is discarded.
REQ-027 Priority: freeze_all > flush > hazard_stall; at most one of {freeze_all, hazard_stall, flush_*} is active in any cycle.
REQ-028 flush_id2exe is not driven by hazard_stall; the bubble is produced by the ID2EXE control inputs being zeroed by the ID stage when hazard_stall=1.
REQ-029 stall_cnt increments by 1 on each edge where freeze_all|hazard_stall=1, and holds at 16'hFFFF.
REQ-030 busy = (state==MEM_WAIT), registered-state-derived, glitch-free.
REQ-031 All outputs except stall_cnt and busy are combinational from the inputs and state.

Reset
REQ-032 While rst=1: state=RUN, wait_cnt=0, stall_cnt=0, busy=0; freeze_all, hazard_stall, flush_if2id and flush_id2exe are forced to 0 regardless of inputs.
REQ-033 Reset asserted mid-MEM_WAIT aborts the sequence immediately; the first edge after deassertion evaluates in RUN.

Verification
REQ-034 mem_r_en=1 for 4 cycles, WAIT_CYCLES=4 -> freeze_all=1,1,1,0; busy=0,1,1,1; stall_cnt=3.
REQ-035 exe_wb_en=1, exe_dest=5, src1=5, no mem_acc -> hazard_stall=1, flushes=0; with two_src=0 and only src2=5 -> hazard_stall=0.
REQ-036 branch_taken=1 together with raw=1 in RUN -> flush_if2id=flush_id2exe=1, hazard_stall=0.
REQ-037 branch_taken=1 asserted during MEM_WAIT (WAIT_CYCLES=4) -> flushes stay 0 until the release cycle, then flushes=1 for that one cycle.
REQ-038 Preload 65534 stall cycles, then apply 3 more -> stall_cnt=16'hFFFF and holds.
REQ-039 rst pulsed while wait_cnt=1 -> freeze_all=0 and busy=0 immediately; stall_cnt=0; the next mem_acc restarts a full 4-cycle sequence.

Source files
------------

// File: rtl/pipe_hazard_ctrl_if.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl_if
//   Bundles the hazard controller's pipeline-side signals.
//   master : pipeline datapath (drives stage information, receives controls)
//   slave  : pipe_hazard_ctrl (samples stage information, drives controls)
//   Stage information : src1, src2, two_src, exe_dest, exe_wb_en, mem_dest,
//                       mem_wb_en, mem_r_en, mem_w_en, branch_taken
//   Controls          : freeze_all, hazard_stall, flush_if2id, flush_id2exe,
//                       busy, stall_cnt
// ---------------------------------------------------------------------------
interface pipe_hazard_ctrl_if;
    logic [3:0]  src1;
    logic [3:0]  src2;
    logic        two_src;
    logic [3:0]  exe_dest;
    logic        exe_wb_en;
    logic [3:0]  mem_dest;
    logic        mem_wb_en;
    logic        mem_r_en;
    logic        mem_w_en;
    logic        branch_taken;
    logic        freeze_all;
    logic        hazard_stall;
    logic        flush_if2id;
    logic        flush_id2exe;
    logic        busy;
    logic [15:0] stall_cnt;

    modport master (
        output src1, src2, two_src, exe_dest, exe_wb_en, mem_dest, mem_wb_en,
               mem_r_en, mem_w_en, branch_taken,
        input  freeze_all, hazard_stall, flush_if2id, flush_id2exe, busy,
               stall_cnt
    );

    modport slave (
        input  src1, src2, two_src, exe_dest, exe_wb_en, mem_dest, mem_wb_en,
               mem_r_en, mem_w_en, branch_taken,
        output freeze_all, hazard_stall, flush_if2id, flush_id2exe, busy,
               stall_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipe_hazard_ctrl
//   Pipeline hazard controller: freezes the whole pipeline for the duration
//   of a multi-cycle memory access, flushes IF/ID and ID/EXE on a taken
//   branch, and stalls the front end on a read-after-write dependency.
//   Ports:
//     clk : clock, all state on rising edge
//     rst : asynchronous active-high reset
//     hz  : pipe_hazard_ctrl_if.slave (stage information in, controls out)
//   Parameter:
//     WAIT_CYCLES : total cycles a memory access occupies MEM (2..8)
// ---------------------------------------------------------------------------
module pipe_hazard_ctrl #(
    parameter int unsigned WAIT_CYCLES = 4
) (
    input  logic               clk,
    input  logic               rst,
    pipe_hazard_ctrl_if.slave  hz
);

    typedef enum logic [0:0] {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } state_t;

    // First frozen cycle happens in RUN, the release cycle at count 0,
    // so MEM_WAIT is entered with WAIT_CYCLES-2 cycles still to freeze.
    localparam logic [2:0] WAIT_LOAD = 3'(WAIT_CYCLES - 32'd2);

    state_t      state_r;
    logic [2:0]  wait_cnt_r;
    logic        busy_r;
    logic [15:0] stall_cnt_r;

    logic        mem_acc_s;
    logic        raw_s;
    logic        freeze_s;
    logic        flush_s;
    logic        hazard_s;

    // A pending write to the register a source operand reads.
    function automatic logic dest_hit(
        input logic       wb_en,
        input logic [3:0] dest,
        input logic [3:0] src
    );
        return wb_en & (dest == src);
    endfunction

    // Memory request and read-after-write detection.
    always_comb begin
        mem_acc_s = hz.mem_r_en | hz.mem_w_en;
        raw_s     = dest_hit(hz.exe_wb_en, hz.exe_dest, hz.src1)
                  | dest_hit(hz.mem_wb_en, hz.mem_dest, hz.src1)
                  | (hz.two_src & (dest_hit(hz.exe_wb_en, hz.exe_dest, hz.src2)
                                 | dest_hit(hz.mem_wb_en, hz.mem_dest, hz.src2)));
    end

    // Freeze decision; in MEM_WAIT new requests are ignored, only the count matters.
    always_comb begin
        freeze_s = 1'b0;
        if (rst) begin
            freeze_s = 1'b0;
        end else begin
            case (state_r)
                RUN:      freeze_s = mem_acc_s;
                MEM_WAIT: freeze_s = (wait_cnt_r != 3'd0);
                default:  freeze_s = 1'b0;
            endcase
        end
    end

    // Priority: freeze hides flush (branch deferred), flush hides the hazard.
    always_comb begin
        flush_s  = 1'b0;
        hazard_s = 1'b0;
        if (rst || freeze_s) begin
            flush_s  = 1'b0;
            hazard_s = 1'b0;
        end else if (hz.branch_taken) begin
            flush_s  = 1'b1;
            hazard_s = 1'b0;
        end else begin
            flush_s  = 1'b0;
            hazard_s = raw_s;
        end
    end

    // Memory-access FSM with registered busy flag.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= RUN;
            wait_cnt_r <= 3'd0;
            busy_r     <= 1'b0;
        end else begin
            case (state_r)
                RUN: begin
                    if (mem_acc_s) begin
                        state_r    <= MEM_WAIT;
                        wait_cnt_r <= WAIT_LOAD;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= RUN;
                        wait_cnt_r <= 3'd0;
                        busy_r     <= 1'b0;
                    end
                end
                MEM_WAIT: begin
                    if (wait_cnt_r != 3'd0) begin
                        state_r    <= MEM_WAIT;
                        wait_cnt_r <= wait_cnt_r - 3'd1;
                        busy_r     <= 1'b1;
                    end else begin
                        state_r    <= RUN;
                        wait_cnt_r <= 3'd0;
                        busy_r     <= 1'b0;
                    end
                end
                default: begin
                    state_r    <= RUN;
                    wait_cnt_r <= 3'd0;
                    busy_r     <= 1'b0;
                end
            endcase
        end
    end

    // Saturating count of cycles in which the pipeline did not advance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            stall_cnt_r <= 16'd0;
        end else if ((freeze_s || hazard_s) && (stall_cnt_r != 16'hFFFF)) begin
            stall_cnt_r <= stall_cnt_r + 16'd1;
        end else begin
            stall_cnt_r <= stall_cnt_r;
        end
    end

    assign hz.freeze_all   = freeze_s;
    assign hz.hazard_stall = hazard_s;
    assign hz.flush_if2id  = flush_s;
    assign hz.flush_id2exe = flush_s;
    assign hz.busy         = busy_r;
    assign hz.stall_cnt    = stall_cnt_r;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// tb_pipe_hazard_ctrl
//   Scoreboard bench: every driven cycle pushes the reference model's
//   expected controls into a queue; a monitor on the falling edge pops and
//   compares. Directed scenarios also check literal expected values.
// ---------------------------------------------------------------------------
module tb_pipe_hazard_ctrl;

    localparam int WAIT = 4;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    pipe_hazard_ctrl_if hz ();

    pipe_hazard_ctrl #(.WAIT_CYCLES(WAIT)) dut (
        .clk (clk),
        .rst (rst),
        .hz  (hz)
    );

    typedef struct {
        logic        freeze;
        logic        hazard;
        logic        flush;
        logic        busy;
        logic [15:0] stall;
    } exp_t;

    exp_t sb_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model state: position inside the current access
    // (-1 = no access in progress) and the stall cycle count.
    int   acc_pos = -1;
    int   stall_m = 0;

    task automatic chk(input string name, input int act, input int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s actual=%0d expected=%0d at %0t", name, act, expv, $time);
        end
    endtask

    task automatic clear_inputs();
        hz.src1 = 4'd0; hz.src2 = 4'd0; hz.two_src = 1'b0;
        hz.exe_dest = 4'd0; hz.exe_wb_en = 1'b0;
        hz.mem_dest = 4'd0; hz.mem_wb_en = 1'b0;
        hz.mem_r_en = 1'b0; hz.mem_w_en = 1'b0; hz.branch_taken = 1'b0;
    endtask

    // Derive this cycle's expected controls from the rules and push them.
    task automatic issue();
        exp_t e;
        int   pend[$];
        logic raw;
        if (rst) begin
            acc_pos  = -1;
            stall_m  = 0;
            e.freeze = 1'b0; e.hazard = 1'b0; e.flush = 1'b0;
            e.busy   = 1'b0; e.stall = 16'd0;
        end else begin
            if (hz.exe_wb_en) pend.push_back(int'(hz.exe_dest));
            if (hz.mem_wb_en) pend.push_back(int'(hz.mem_dest));
            raw = 1'b0;
            foreach (pend[k])
                if (pend[k] == int'(hz.src1) || (hz.two_src && pend[k] == int'(hz.src2)))
                    raw = 1'b1;
            if (acc_pos < 0 && (hz.mem_r_en || hz.mem_w_en)) acc_pos = 0;
            e.freeze = (acc_pos >= 0) && (acc_pos < WAIT - 1);
            e.busy   = (acc_pos >= 1);
            e.flush  = hz.branch_taken && !e.freeze;
            e.hazard = raw && !hz.branch_taken && !e.freeze;
            e.stall  = 16'(stall_m);
            if (e.freeze || e.hazard) stall_m = (stall_m < 65535) ? stall_m + 1 : 65535;
            if (acc_pos >= 0) begin
                acc_pos++;
                if (acc_pos == WAIT) acc_pos = -1;
            end
        end
        sb_q.push_back(e);
    endtask

    task automatic advance();
        @(posedge clk);
        #1;
    endtask

    // Monitor: one expectation per cycle, compared on the falling edge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (sb_q.size() > 0) begin
                e = sb_q.pop_front();
                chk("sb_freeze_all",   int'(hz.freeze_all),   int'(e.freeze));
                chk("sb_hazard_stall", int'(hz.hazard_stall), int'(e.hazard));
                chk("sb_flush_if2id",  int'(hz.flush_if2id),  int'(e.flush));
                chk("sb_flush_id2exe", int'(hz.flush_id2exe), int'(e.flush));
                chk("sb_busy",         int'(hz.busy),         int'(e.busy));
                chk("sb_stall_cnt",    int'(hz.stall_cnt),    int'(e.stall));
            end
        end
    end

    // Watchdog so the run always terminates.
    initial begin
        #3_000_000;
        $display("FAIL watchdog time limit expired");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [3:0] fz_pat;
        logic [3:0] bz_pat;
        logic [3:0] fl_pat;
        fz_pat = 4'b1110;
        bz_pat = 4'b0111;
        fl_pat = 4'b0001;

        rst = 1'b1;
        clear_inputs();
        @(posedge clk);
        #1;

        // Reset state, even with a request present.
        hz.mem_r_en = 1'b1; hz.branch_taken = 1'b1;
        issue(); #3;
        chk("rst_freeze", int'(hz.freeze_all), 0);
        chk("rst_flush",  int'(hz.flush_if2id), 0);
        chk("rst_busy",   int'(hz.busy), 0);
        chk("rst_stall",  int'(hz.stall_cnt), 0);
        advance();
        clear_inputs();
        rst = 1'b0;

        // Four-cycle memory read.
        hz.mem_r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(); #3;
            chk("mem_freeze", int'(hz.freeze_all), int'(fz_pat[3-i]));
            chk("mem_busy",   int'(hz.busy),       int'(bz_pat[3-i]));
            advance();
        end
        hz.mem_r_en = 1'b0;
        issue(); #3;
        chk("mem_stall_cnt", int'(hz.stall_cnt), 3);
        advance();

        // RAW on src1, ignored src2, then src2 with two_src.
        hz.exe_wb_en = 1'b1; hz.exe_dest = 4'd5; hz.src1 = 4'd5;
        issue(); #3;
        chk("raw_src1_stall", int'(hz.hazard_stall), 1);
        chk("raw_src1_flush", int'(hz.flush_id2exe), 0);
        advance();
        hz.src1 = 4'd0; hz.src2 = 4'd5; hz.two_src = 1'b0;
        issue(); #3;
        chk("raw_src2_one_src", int'(hz.hazard_stall), 0);
        advance();
        hz.two_src = 1'b1;
        issue(); #3;
        chk("raw_src2_two_src", int'(hz.hazard_stall), 1);
        advance();

        // Branch outranks the hazard.
        hz.branch_taken = 1'b1;
        issue(); #3;
        chk("br_flush_if2id",  int'(hz.flush_if2id), 1);
        chk("br_flush_id2exe", int'(hz.flush_id2exe), 1);
        chk("br_no_stall",     int'(hz.hazard_stall), 0);
        advance();
        clear_inputs();

        // Branch during MEM_WAIT deferred to the release cycle.
        hz.mem_w_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            if (i == 1) begin hz.mem_w_en = 1'b0; hz.branch_taken = 1'b1; end
            issue(); #3;
            chk("defer_flush", int'(hz.flush_if2id), int'(fl_pat[3-i]));
            advance();
        end
        clear_inputs();

        // Reset pulsed while wait_cnt == 1, then a full fresh sequence.
        hz.mem_r_en = 1'b1;
        issue(); advance();
        hz.mem_r_en = 1'b0;
        issue(); advance();
        rst = 1'b1;
        issue(); #3;
        chk("rst_mid_freeze", int'(hz.freeze_all), 0);
        chk("rst_mid_busy",   int'(hz.busy), 0);
        chk("rst_mid_stall",  int'(hz.stall_cnt), 0);
        advance();
        rst = 1'b0;
        hz.mem_r_en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            issue(); #3;
            chk("restart_freeze", int'(hz.freeze_all), int'(fz_pat[3-i]));
            chk("restart_busy",   int'(hz.busy),       int'(bz_pat[3-i]));
            advance();
        end
        clear_inputs();

        // Randomized traffic, including back-to-back accesses and resets.
        for (int i = 0; i < 2000; i++) begin
            rst             = ($urandom_range(0, 249) == 0);
            hz.src1         = 4'($urandom_range(0, 3));
            hz.src2         = 4'($urandom_range(0, 3));
            hz.two_src      = 1'($urandom_range(0, 1));
            hz.exe_dest     = 4'($urandom_range(0, 3));
            hz.exe_wb_en    = 1'($urandom_range(0, 1));
            hz.mem_dest     = 4'($urandom_range(0, 3));
            hz.mem_wb_en    = 1'($urandom_range(0, 1));
            hz.mem_r_en     = ($urandom_range(0, 5) == 0);
            hz.mem_w_en     = ($urandom_range(0, 7) == 0);
            hz.branch_taken = ($urandom_range(0, 4) == 0);
            issue(); advance();
        end
        rst = 1'b1;
        clear_inputs();
        issue(); advance();
        rst = 1'b0;

        // Saturation: 65534 stalled cycles, then 3 more.
        hz.exe_wb_en = 1'b1; hz.exe_dest = 4'd9; hz.src1 = 4'd9;
        for (int i = 0; i < 65534; i++) begin
            issue(); advance();
        end
        issue(); #3;
        chk("sat_preload", int'(hz.stall_cnt), 65534);
        advance();
        issue(); advance();
        issue(); #3;
        chk("sat_reached", int'(hz.stall_cnt), 65535);
        advance();
        clear_inputs();
        issue(); #3;
        chk("sat_hold", int'(hz.stall_cnt), 65535);
        advance();
        issue(); advance();

        @(negedge clk);
        #1;
        chk("sb_drain", sb_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
